// File: rtl/event_unit_pkg.sv
// Shared types and constants for the cluster event unit barrier.
package event_unit_pkg;

  localparam int unsigned MAX_CORES = 32;
  localparam int unsigned CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    RELEASE   = 2'd2,
    WAIT_WAKE = 2'd3
  } barrier_state_e;

endpackage

// File: rtl/event_unit_barrier_stats.sv
// Barrier statistics counters: completed barriers and cycles spent waiting.
// Only present when BARRIER_STATS_EN is defined.
`ifdef BARRIER_STATS_EN
module event_unit_barrier_stats
  import event_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             release_i,
  input  logic             wait_i,
  output logic [CNT_W-1:0] barrier_cnt_o,
  output logic [CNT_W-1:0] wait_cyc_o
);

  logic [CNT_W-1:0] barrier_cnt_q, barrier_cnt_d;
  logic [CNT_W-1:0] wait_cyc_q, wait_cyc_d;

  // Clear wins over increment; both counters wrap naturally.
  always_comb begin
    barrier_cnt_d = barrier_cnt_q;
    wait_cyc_d    = wait_cyc_q;
    if (clear_i) begin
      barrier_cnt_d = '0;
      wait_cyc_d    = '0;
    end else begin
      if (release_i) barrier_cnt_d = barrier_cnt_q + CNT_W'(1);
      if (wait_i)    wait_cyc_d    = wait_cyc_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      barrier_cnt_q <= '0;
      wait_cyc_q    <= '0;
    end else begin
      barrier_cnt_q <= barrier_cnt_d;
      wait_cyc_q    <= wait_cyc_d;
    end
  end

  assign barrier_cnt_o = barrier_cnt_q;
  assign wait_cyc_o    = wait_cyc_q;

endmodule
`endif

// File: rtl/event_unit_barrier.sv
// Cluster hardware barrier: collects per-core arrivals against a participant
// mask, fires a one-cycle wake event, then waits for all participants to
// leave clock gating before re-arming. Optional stats under BARRIER_STATS_EN.
module event_unit_barrier
  import event_unit_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [NUM_CORES-1:0] cfg_mask_i,
  input  logic [NUM_CORES-1:0] arrive_i,
  input  logic [NUM_CORES-1:0] core_gated_i,
  output logic [NUM_CORES-1:0] event_o,
  output logic [NUM_CORES-1:0] arrived_o,
  output logic                 busy_o,
  output logic                 cfg_err_o
`ifdef BARRIER_STATS_EN
  ,
  input  logic                 clear_stats_i,
  output logic [CNT_W-1:0]     barrier_cnt_o,
  output logic [CNT_W-1:0]     wait_cyc_o
`endif
);

  barrier_state_e state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] arrived_q, arrived_d;
  logic [NUM_CORES-1:0] early_q, early_d;
  logic [NUM_CORES-1:0] event_q, event_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [NUM_CORES-1:0] arr_part;

  assign arr_part = arrive_i & mask_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    arrived_d = arrived_q;
    early_d   = early_q;
    event_d   = '0;
    err_d     = cfg_we_i && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          mask_d = cfg_mask_i;
          if (cfg_mask_i != '0) state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (((arrived_q | arrive_i) & mask_q) == mask_q) begin
          state_d   = RELEASE;
          arrived_d = '0;
          event_d   = mask_q;
        end else begin
          arrived_d = arrived_q | arr_part;
        end
      end
      RELEASE: begin
        early_d = early_q | arr_part;
        state_d = WAIT_WAKE;
      end
      WAIT_WAKE: begin
        if ((core_gated_i & mask_q) == '0) begin
          state_d   = COLLECT;
          arrived_d = early_q | arr_part;
          early_d   = '0;
        end else begin
          early_d = early_q | arr_part;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      arrived_q <= '0;
      early_q   <= '0;
      event_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      arrived_q <= arrived_d;
      early_q   <= early_d;
      event_q   <= event_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign event_o   = event_q;
  assign arrived_o = arrived_q;
  assign busy_o    = busy_q;
  assign cfg_err_o = err_q;

`ifdef BARRIER_STATS_EN
  event_unit_barrier_stats u_stats (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_stats_i),
    .release_i    (state_q == RELEASE),
    .wait_i       ((state_q == COLLECT) || (state_q == WAIT_WAKE)),
    .barrier_cnt_o(barrier_cnt_o),
    .wait_cyc_o   (wait_cyc_o)
  );
`endif

endmodule

// File: doc/event_unit_barrier.md
# event_unit_barrier

Cluster hardware barrier that releases sleeping cores. It collects per-core arrival requests against a programmable participant mask. When the last participant arrives, it drives a one-cycle wake event to every participant, and the per-core event_unit_sm instances latch that event as their event-detect input. It then waits until every participant has left the clock-gated state before arming the next barrier.

## Interface
- NUM_CORES, 4, number of cores served, 1..32
- clk_i  in  1  cluster clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_we_i  in  1  write strobe for participant mask
- cfg_mask_i  in  NUM_CORES  participant mask; bit i = core i takes part
- arrive_i  in  NUM_CORES  one-cycle arrival pulse per core, issued with its sleep request
- core_gated_i  in  NUM_CORES  per-core clock-gate status from event_unit_sm
- event_o  out  NUM_CORES  registered one-cycle wake event per core
- arrived_o  out  NUM_CORES  current arrival mask
- busy_o  out  1  high when state is not IDLE
- cfg_err_o  out  1  one-cycle pulse when a mask write is rejected
- Only with BARRIER_STATS_EN: clear_stats_i in 1; barrier_cnt_o out 32; wait_cyc_o out 32

## Operation
- State machine states: IDLE, COLLECT, RELEASE, WAIT_WAKE.
- IDLE
  - cfg_we_i with a nonzero mask loads mask_q and goes to COLLECT.
  - A zero mask is loaded but the state stays IDLE, so the barrier is disabled.
- COLLECT
  - arrived_q |= arrive_i & mask_q.
  - Arrivals from non-participants are ignored.
  - A duplicate arrival has no effect.
  - When ((arrived_q | arrive_i) & mask_q) == mask_q, go to RELEASE and clear arrived_q.
- RELEASE
  - Lasts one cycle; event_o = mask_q.
  - Always go to WAIT_WAKE next.
- WAIT_WAKE
  - Stay until (core_gated_i & mask_q) == 0, then go to COLLECT.
  - A participant arriving in RELEASE or WAIT_WAKE is latched into early_q and merged into arrived_q on entry to COLLECT, so it is never lost.
- Mask writes outside IDLE are ignored and pulse cfg_err_o for one cycle. The mask is changed only by reset or an IDLE write.
- Simultaneous events
  - If cfg_we_i and arrive_i coincide in IDLE, arrive_i is dropped.
  - A single-participant mask releases on that core's first arrival.
- Reset values: all outputs 0, state IDLE, mask_q 0, arrived_q 0, early_q 0, counters 0.
- Reset mid-barrier aborts the barrier. No event is generated.

## Timing
- Arrival at posedge N is visible on arrived_o after N.
- If the arrival at posedge N completes the mask, event_o is high from N to N+1, for exactly one cycle.
- busy_o follows the registered state with no extra latency.
- Minimum barrier period is 3 cycles (COLLECT, RELEASE, WAIT_WAKE), achieved when core_gated_i is already low.
- WAIT_WAKE has no timeout. A participant whose gate never drops stalls the barrier until reset.
- cfg_err_o goes high in the cycle after the rejected write.

## Configuration
- BARRIER_STATS_EN defined
  - barrier_cnt_o increments on each RELEASE.
  - wait_cyc_o increments on every cycle spent in COLLECT or WAIT_WAKE.
  - Both counters wrap at 2^32.
  - clear_stats_i zeroes both counters and takes priority over increment in the same cycle.
- BARRIER_STATS_EN undefined: the three stats ports and their logic are absent.

## Structure
- event_unit_pkg holds:
  - the state enum typedef (2 bits: IDLE, COLLECT, RELEASE, WAIT_WAKE);
  - the MAX_CORES = 32 constant.
- Optional sub-module event_unit_barrier_stats holds both counters with clear. It is instantiated only under BARRIER_STATS_EN.

## Test plan
- Mask 4'b1111; cores arrive in order 0, 2, 1, 3 on separate cycles -> event_o = 4'b1111 for one cycle directly after the core-3 arrival; arrived_o returns to 0.
- Mask 4'b0101; core 1 arrives, then cores 0 and 2 arrive together -> core 1 is ignored; event_o = 4'b0101 one cycle later.
- Mask 4'b0011; core_gated_i = 2'b11 held for 5 cycles after release; core 0 re-arrives during that time -> state holds in WAIT_WAKE; on return to COLLECT arrived_o = 4'b0001.
- Mask write of 4'b0001 while in COLLECT -> cfg_err_o pulses once; mask_q is unchanged.
- Reset asserted mid-COLLECT with arrived_o = 4'b0110 -> all outputs 0 asynchronously; no event_o after release.
- With BARRIER_STATS_EN: three barriers with a 4-cycle collect each -> barrier_cnt_o = 3; clear_stats_i -> both counters 0.
